pipe_field: RTL and testbench
=============================

# pipe_field

Multi-pipe obstacle engine for the Flappy Bird datapath: generalises the single-pipe mover to `NUM_PIPES` independently scrolling pipes with pseudo-random gap heights, selectable scroll speed, per-pipe pass scoring and bird/pipe plus floor/ceiling collision detection. It sits between the frame-tick source (derived from VGA_VS), the bird block (bird Y) and the colour mapper (pipe pixel flag). It replaces the separate pipe, collision and score instances at top level.

## Interface
- `NUM_PIPES`, 3: pipes in rotation (1..8).
- `SCREEN_W`, 640 / `SCREEN_H`, 480: visible area in pixels.
- `PIPE_W`, 48: pipe width in pixels.
- `PIPE_SPACING`, 240: right-edge distance between adjacent pipes.
- `GAP_H`, 128: vertical gap height.
- `GAP_MIN`, 64: smallest gap top Y.
- `BIRD_X`, 160: fixed bird centre X.
- `BIRD_R`, 8: bird half-size (the bird is a square box).
- `SCORE_W`, 8: score width.
- Legality: `NUM_PIPES*PIPE_SPACING + SCREEN_W + PIPE_W < 2048`; `PIPE_SPACING > 4`.

Ports:
- `Clk` in 1: system clock (50 MHz).
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame, synchronous to `Clk`.
- `start` in 1: level/pulse; IDLE→RUN.
- `restart` in 1: pulse; any state→IDLE.
- `speed` in 2: scroll step = `speed+1` px/frame.
- `bird_y` in 10: bird centre Y.
- `DrawX`, `DrawY` in 10: current pixel.
- `is_pipe` out 1: pixel lies in a pipe body.
- `collision` out 1: sticky hit flag.
- `pass_pulse` out 1: one-cycle pulse per pipe cleared.
- `score` out `SCORE_W`: saturating pass count.

## Operation
- States: IDLE (pipes parked, no motion, no scoring/collision), RUN, DEAD (frozen, `collision`=1).
- Transitions: IDLE→RUN on `start`; RUN→DEAD on a detected hit; any state→IDLE on `restart`. `restart` has priority over everything. `start` is ignored in RUN/DEAD.
- Per pipe i: right edge `xr` is 11-bit unsigned. The body occupies columns `xr-PIPE_W .. xr-1` and all rows outside `[gap_y, gap_y+GAP_H)`. `gap_y` is 10 bits.
- IDLE/reset values: `xr_i = SCREEN_W+PIPE_W+i*PIPE_SPACING`, `gap_y_i = GAP_MIN+64`, LFSR = 16'hACE1, score 0.
- RUN and `frame_tick`:
  - For each pipe, `xr -= step`.
  - If `xr <= step`, the pipe wraps instead: `xr = xr - step + NUM_PIPES*PIPE_SPACING` and `gap_y = GAP_MIN + lfsr[6:0]`.
  - The LFSR is 16-bit Galois with taps 16'hB400. It advances once per tick in RUN, after being sampled.
- Pass: on a tick where old `xr > BIRD_X` and new `xr <= BIRD_X`, pulse `pass_pulse` and increment `score`. `score` saturates at all-ones. If several pipes pass on one tick, the score still increments by 1.
- Hit (evaluated every cycle in RUN on registered values), any of:
  - bird box `[BIRD_X-BIRD_R, BIRD_X+BIRD_R] × [bird_y-BIRD_R, bird_y+BIRD_R]` overlaps a pipe body;
  - `bird_y < BIRD_R`;
  - `bird_y+BIRD_R >= SCREEN_H`.
- If a hit and a pass occur in the same cycle, the pass is suppressed.
- DEAD holds all positions and score until `restart`. `restart` clears score.

## Timing
- Reset values: `is_pipe`=0, `collision`=0, `pass_pulse`=0, `score`=0, state IDLE.
- Motion registers update on the `Clk` edge ending the `frame_tick` cycle.
- `pass_pulse` and `score` update in that same edge, so both are visible 1 cycle after the tick.
- Hit: combinational compare registered at edge t+1. `collision` and the DEAD state become visible at t+1. A `frame_tick` coincident with detection still moves the pipes.
- `is_pipe`: registered, valid 1 cycle after `DrawX`/`DrawY`. It is driven in all states, including IDLE and DEAD.
- `restart`: all registers return to IDLE values at the next edge. A tick in the same cycle is ignored.
- Reset assertion mid-frame clears everything immediately (asynchronous). Deassertion must be synchronised externally.

## Structure
- Package `pipe_field_pkg`: state enum (IDLE/RUN/DEAD), LFSR seed and tap constants, the `PIX_W`=10 and `POS_W`=11 width constants.
- Sub-module `pipe_lane`, generated `NUM_PIPES` times. It holds `xr`/`gap_y`, applies move/wrap, and outputs `wrap_req`, `pass`, `hit` and `draw` flags.
- The top holds the FSM, LFSR, score and output OR-reductions.

## Test plan
- Reset, then sample all pipe edges → `xr` = 688/928/1168, `gap_y`=128, `score`=0, `is_pipe`=0 at `DrawX`=639.
- `start`, `speed`=0, `bird_y`=192, then 528 ticks → `pass_pulse` one cycle after tick 528, `score`=1, `collision`=0.
- `start`, `speed`=0, `bird_y`=100 → `collision`=1 one cycle after tick 472 (`xr`=216). Further ticks → no `xr` change.
- `speed`=3, 200 ticks → pipe 0 wraps once. Check new `xr` = 720+(688−172·4)… per formula, and `gap_y` = 64+LFSR[6:0] against the reference model.
- `bird_y`=5 in RUN → `collision` next cycle. Assert `restart` together with `frame_tick` → IDLE values, `score`=0.
- Force `score`=255 via 255 passes → next pass keeps `score`=255 with `pass_pulse`=1. Assert `Reset_n` low mid-run → immediate reset values.

Source files
------------

// File: rtl/pipe_field_pkg.sv
// Shared types and constants for the multi-pipe obstacle engine.
package pipe_field_pkg;

    localparam int PIX_W = 10;
    localparam int POS_W = 11;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/pipe_field_lane.sv
// One scrolling pipe: position/gap registers, move-and-wrap, and the
// pass, bird-hit and pixel-draw flags derived from its registered state.
module pipe_lane
    import pipe_field_pkg::*;
#(
    parameter int INIT_XR   = 688,
    parameter int WRAP_DIST = 720,
    parameter int PIPE_W    = 48,
    parameter int GAP_H     = 128,
    parameter int GAP_MIN   = 64,
    parameter int BIRD_X    = 160,
    parameter int BIRD_R    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             move,
    input  logic             gap_load,
    input  logic [2:0]       step,
    input  logic [6:0]       rnd,
    input  logic [PIX_W-1:0] bird_y,
    input  logic [PIX_W-1:0] draw_x,
    input  logic [PIX_W-1:0] draw_y,
    output logic             wrap_req,
    output logic             pass,
    output logic             hit,
    output logic             draw
);

    localparam logic [POS_W-1:0] XR_INIT  = POS_W'(INIT_XR);
    localparam logic [POS_W-1:0] WRAP_ADD = POS_W'(WRAP_DIST);
    localparam logic [PIX_W-1:0] GAP_INIT = PIX_W'(GAP_MIN + 64);
    localparam logic [PIX_W-1:0] GAP_BASE = PIX_W'(GAP_MIN);
    localparam logic [POS_W-1:0] BIRD_XW  = POS_W'(BIRD_X);
    // Bird box spans columns BIRD_X-R..BIRD_X+R; the body spans xr-PIPE_W..xr-1.
    localparam logic [POS_W-1:0] HIT_X_LO = POS_W'(BIRD_X - BIRD_R);
    localparam logic [POS_W-1:0] HIT_X_HI = POS_W'(BIRD_X + BIRD_R + PIPE_W);
    localparam logic [POS_W-1:0] PIPE_WW  = POS_W'(PIPE_W);
    localparam logic [POS_W-1:0] GAP_HW   = POS_W'(GAP_H);
    localparam logic [POS_W-1:0] BIRD_RW  = POS_W'(BIRD_R);

    logic [POS_W-1:0] xr;
    logic [PIX_W-1:0] gap_y;
    logic [POS_W-1:0] step_w, xr_next, gap_lo, gap_hi, bird_w, dx, dy;

    // Next position, wrap request and the three geometric flags.
    always_comb begin
        step_w   = POS_W'(step);
        wrap_req = (xr <= step_w);
        xr_next  = xr - step_w;
        if (wrap_req) begin
            xr_next = xr_next + WRAP_ADD;
        end
        pass   = move && (xr > BIRD_XW) && (xr_next <= BIRD_XW);
        gap_lo = POS_W'(gap_y);
        gap_hi = gap_lo + GAP_HW;
        bird_w = POS_W'(bird_y);
        dx     = POS_W'(draw_x);
        dy     = POS_W'(draw_y);
        // Top edge above the gap compared as bird_y < gap_y + R to avoid underflow.
        hit    = (xr > HIT_X_LO) && (xr <= HIT_X_HI) &&
                 ((bird_w < gap_lo + BIRD_RW) || (bird_w + BIRD_RW >= gap_hi));
        draw   = (dx < xr) && (dx + PIPE_WW >= xr) && ((dy < gap_lo) || (dy >= gap_hi));
    end

    // Position and gap registers; load parks the pipe at its idle slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr    <= XR_INIT;
            gap_y <= GAP_INIT;
        end else if (load) begin
            xr    <= XR_INIT;
            gap_y <= GAP_INIT;
        end else begin
            if (move) begin
                xr <= xr_next;
            end
            if (gap_load) begin
                gap_y <= GAP_BASE + PIX_W'(rnd);
            end
        end
    end

endmodule

// File: rtl/pipe_field.sv
// Multi-pipe obstacle engine: game FSM, gap LFSR, pass scoring and
// OR-reduction of the per-lane hit/draw flags.
module pipe_field
    import pipe_field_pkg::*;
#(
    parameter int NUM_PIPES    = 3,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PIPE_W       = 48,
    parameter int PIPE_SPACING = 240,
    parameter int GAP_H        = 128,
    parameter int GAP_MIN      = 64,
    parameter int BIRD_X       = 160,
    parameter int BIRD_R       = 8,
    parameter int SCORE_W      = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               restart,
    input  logic [1:0]         speed,
    input  logic [PIX_W-1:0]   bird_y,
    input  logic [PIX_W-1:0]   DrawX,
    input  logic [PIX_W-1:0]   DrawY,
    output logic               is_pipe,
    output logic               collision,
    output logic               pass_pulse,
    output logic [SCORE_W-1:0] score
);

    localparam logic [POS_W-1:0] BIRD_RW   = POS_W'(BIRD_R);
    localparam logic [POS_W-1:0] SCREEN_HW = POS_W'(SCREEN_H);

    state_t state, state_next;
    logic running, move, hit_any, pass_ev;
    logic [15:0] lfsr;
    logic [2:0]  step;
    logic [NUM_PIPES-1:0] wrap_req, gap_load, pass, hit, draw;

    assign step     = {1'b0, speed} + 3'd1;
    assign move     = running && frame_tick && !restart;
    assign gap_load = wrap_req & {NUM_PIPES{move}};
    assign hit_any  = running && ((|hit) || (POS_W'(bird_y) < BIRD_RW) ||
                                  (POS_W'(bird_y) + BIRD_RW >= SCREEN_HW));
    // A hit on the same cycle cancels the pass; several passes count once.
    assign pass_ev  = (|pass) && !hit_any;

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_lane
        pipe_lane #(
            .INIT_XR  (SCREEN_W + PIPE_W + i * PIPE_SPACING),
            .WRAP_DIST(NUM_PIPES * PIPE_SPACING),
            .PIPE_W   (PIPE_W),
            .GAP_H    (GAP_H),
            .GAP_MIN  (GAP_MIN),
            .BIRD_X   (BIRD_X),
            .BIRD_R   (BIRD_R)
        ) u_lane (
            .clk     (Clk),
            .rst_n   (Reset_n),
            .load    (restart),
            .move    (move),
            .gap_load(gap_load[i]),
            .step    (step),
            .rnd     (lfsr[6:0]),
            .bird_y  (bird_y),
            .draw_x  (DrawX),
            .draw_y  (DrawY),
            .wrap_req(wrap_req[i]),
            .pass    (pass[i]),
            .hit     (hit[i]),
            .draw    (draw[i])
        );
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // FSM next state; restart overrides everything.
    always_comb begin
        state_next = state;
        if (restart) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)   state_next = RUN;
                RUN:     if (hit_any) state_next = DEAD;
                DEAD:    state_next = DEAD;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        running   = (state == RUN);
        collision = (state == DEAD);
    end

    // Gap LFSR, sampled by wrapping lanes then advanced on each running tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)     lfsr <= LFSR_SEED;
        else if (restart) lfsr <= LFSR_SEED;
        else if (move)    lfsr <= lfsr_next(lfsr);
    end

    // Pass pulse and saturating score.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pass_pulse <= 1'b0;
            score      <= '0;
        end else begin
            pass_pulse <= pass_ev;
            if (restart) begin
                score <= '0;
            end else if (pass_ev && (score != '1)) begin
                score <= score + 1'b1;
            end
        end
    end

    // Registered pixel flag, active in every state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) is_pipe <= 1'b0;
        else          is_pipe <= |draw;
    end

endmodule

// File: tb/tb_pipe_field.sv
// Directed bench for pipe_field: scroll, pass, collision, wrap, restart
// and saturation scenarios with hand-computed expectations.
module tb_pipe_field;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [9:0] bird_y = 10'd192;
    logic [9:0] DrawX = 10'd639;
    logic [9:0] DrawY = 10'd0;
    logic       is_pipe, collision, pass_pulse;
    logic [7:0] score;

    int tests = 0;
    int fails = 0;

    pipe_field dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_tick(frame_tick),
        .start     (start),
        .restart   (restart),
        .speed     (speed),
        .bird_y    (bird_y),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .is_pipe   (is_pipe),
        .collision (collision),
        .pass_pulse(pass_pulse),
        .score     (score)
    );

    always #5 Clk = ~Clk;

    logic [10:0] xr0, xr1, xr2;
    logic [9:0]  gap0, gap1, gap2;
    logic [15:0] lfsr_dut;
    assign xr0      = dut.g_lane[0].u_lane.xr;
    assign xr1      = dut.g_lane[1].u_lane.xr;
    assign xr2      = dut.g_lane[2].u_lane.xr;
    assign gap0     = dut.g_lane[0].u_lane.gap_y;
    assign gap1     = dut.g_lane[1].u_lane.gap_y;
    assign gap2     = dut.g_lane[2].u_lane.gap_y;
    assign lfsr_dut = dut.lfsr;

    function automatic logic [15:0] model_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic tick();
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
    endtask

    task automatic do_start();
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge Clk) restart = 1'b1;
        @(negedge Clk) restart = 1'b0;
    endtask

    // Keep the bird centred in whichever pipe is approaching it.
    task automatic steer();
        if (xr0 >= 11'd150 && xr0 <= 11'd240)      bird_y = gap0 + 10'd64;
        else if (xr1 >= 11'd150 && xr1 <= 11'd240) bird_y = gap1 + 10'd64;
        else if (xr2 >= 11'd150 && xr2 <= 11'd240) bird_y = gap2 + 10'd64;
    endtask

    initial begin
        logic [15:0] m;
        int n;

        // Reset values
        cyc(); cyc();
        Reset_n = 1'b1;
        cyc();
        check("rst_xr0", xr0, 688);
        check("rst_xr1", xr1, 928);
        check("rst_xr2", xr2, 1168);
        check("rst_gap0", gap0, 128);
        check("rst_score", score, 0);
        check("rst_coll", collision, 0);
        check("rst_pass", pass_pulse, 0);
        check("rst_is_pipe_639", is_pipe, 0);
        DrawX = 10'd640; DrawY = 10'd0;
        cyc();
        check("idle_is_pipe_640", is_pipe, 1);

        // First pass at speed 0
        speed = 2'd0; bird_y = 10'd192;
        do_start();
        repeat (527) tick();
        check("pass_pre_pulse", pass_pulse, 0);
        check("pass_pre_score", score, 0);
        tick();
        check("pass_xr0", xr0, 160);
        check("pass_pulse", pass_pulse, 1);
        check("pass_score", score, 1);
        check("pass_coll", collision, 0);
        DrawX = 10'd120; DrawY = 10'd10;
        cyc();
        check("pass_pulse_width", pass_pulse, 0);
        check("draw_body_top", is_pipe, 1);
        DrawY = 10'd150;
        cyc();
        check("draw_gap", is_pipe, 0);
        DrawX = 10'd112; DrawY = 10'd300;
        cyc();
        check("draw_body_low", is_pipe, 1);
        DrawX = 10'd160;
        cyc();
        check("draw_right_of_edge", is_pipe, 0);

        // Collision with the upper pipe body
        do_restart();
        check("restart_score", score, 0);
        bird_y = 10'd100;
        do_start();
        repeat (471) tick();
        check("hit_pre_coll", collision, 0);
        tick();
        check("hit_xr0", xr0, 216);
        cyc();
        check("hit_coll", collision, 1);
        repeat (5) tick();
        check("dead_xr0_frozen", xr0, 216);
        check("dead_coll_sticky", collision, 1);

        // Speed 3 wrap with a fresh gap
        do_restart();
        check("restart_xr0", xr0, 688);
        speed = 2'd3; bird_y = 10'd192;
        do_start();
        repeat (171) tick();
        check("wrap_pre_xr0", xr0, 4);
        tick();
        m = 16'hACE1;
        repeat (171) m = model_step(m);
        check("wrap_xr0", xr0, 720);
        check("wrap_gap0", gap0, 32'(64 + m[6:0]));
        repeat (28) tick();
        repeat (29) m = model_step(m);
        check("wrap_xr0_200", xr0, 608);
        check("wrap_gap1_kept", gap1, 128);
        check("wrap_lfsr", lfsr_dut, m);
        check("wrap_score", score, 2);
        check("wrap_coll", collision, 0);

        // Floor/ceiling boundaries
        bird_y = 10'd8;
        cyc(); cyc();
        check("ceil_edge_ok", collision, 0);
        bird_y = 10'd471;
        cyc(); cyc();
        check("floor_edge_ok", collision, 0);
        bird_y = 10'd5;
        cyc();
        check("ceil_hit", collision, 1);
        @(negedge Clk) begin restart = 1'b1; frame_tick = 1'b1; end
        @(negedge Clk) begin restart = 1'b0; frame_tick = 1'b0; end
        check("rt_coll", collision, 0);
        check("rt_score", score, 0);
        check("rt_xr0", xr0, 688);
        check("rt_gap0", gap0, 128);
        check("rt_lfsr", lfsr_dut, 16'hACE1);
        tick();
        check("idle_no_move", xr0, 688);
        do_start();
        bird_y = 10'd472;
        cyc();
        check("floor_hit", collision, 1);

        // Saturating score
        do_restart();
        speed = 2'd3; bird_y = 10'd192;
        do_start();
        n = 0;
        while (score != 8'd255 && n < 20000) begin
            steer();
            tick();
            n++;
        end
        check("sat_reach", score, 255);
        n = 0;
        steer();
        tick();
        while (pass_pulse !== 1'b1 && n < 300) begin
            steer();
            tick();
            n++;
        end
        check("sat_pulse", pass_pulse, 1);
        check("sat_hold", score, 255);
        check("sat_coll", collision, 0);

        // Asynchronous reset mid-run
        tick();
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("areset_score", score, 0);
        check("areset_coll", collision, 0);
        check("areset_xr0", xr0, 688);
        check("areset_is_pipe", is_pipe, 0);
        check("areset_pass", pass_pulse, 0);
        @(negedge Clk) Reset_n = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
